io_bus_arbiter: RTL and testbench

- Two-master arbiter and bus sequencer for the 64-entry GPIO/IO register SRAM (cs/oe/we/address/tristate data host port).
- Master 0 is the CPU core's IO access unit; master 1 is the debug/test loader. Each issues single-beat read or write requests.
- The arbiter grants one master at a time (round-robin) and generates the exact cs/we/oe/address/data timing the IO SRAM needs.
- Rejects writes to the read-only pin registers (PINA, PINB) without touching the bus.

---
 rtl/io_bus_arbiter_pkg.sv | 27 ++
 rtl/io_bus_arbiter_rr_arb2.sv | 21 ++
 rtl/io_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg
//   Shared definitions for the IO register bus arbiter: register addresses
//   of the port A/B block, arbiter state encodings and a read-only decode.
package io_bus_arbiter_pkg;

  // IO register map (6-bit register address space)
  localparam logic [5:0] PINB  = 6'h16;
  localparam logic [5:0] DDRB  = 6'h17;
  localparam logic [5:0] PORTB = 6'h18;
  localparam logic [5:0] PINA  = 6'h19;
  localparam logic [5:0] DDRA  = 6'h1A;
  localparam logic [5:0] PORTA = 6'h1B;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_RESP    = 3'd4
  } arb_state_t;

  // Pin registers reflect the pads; writing them is meaningless.
  function automatic logic is_ro(input logic [5:0] addr);
    return (addr == PINA) || (addr == PINB);
  endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-request round-robin picker.
//   req[1:0]   : request vector (bit i = master i)
//   last_grant : index of the master granted most recently
//   gnt_valid  : some request is pending
//   gnt_idx    : chosen master; on contention the one not granted last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) gnt_idx = ~last_grant;
    else if (req[1])  gnt_idx = 1'b1;
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Two-master arbiter and bus sequencer for the 64-entry IO register SRAM.
//   Master 0 = CPU IO access unit, master 1 = debug/test loader. Single-beat
//   requests are granted round-robin and turned into cs/we/oe/addr/data
//   cycles. Writes to pin registers are rejected without a bus cycle.
//   clk, reset           : clock (posedge logic), synchronous active-high reset
//   mN_req/we/addr/wdata : master N request, held until mN_ack
//   mN_ack, mN_err       : one-cycle completion pulse, error (rejected write)
//   rdata                : shared read data, valid with the ack of a read
//   io_cs/we/oe/addr     : IO SRAM control (SRAM samples on negedge)
//   io_data              : IO SRAM data, driven only during a write cycle
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  io_cs,
  output logic                  io_we,
  output logic                  io_oe,
  output logic [ADDR_WIDTH-1:0] io_addr,
  inout  wire  [DATA_WIDTH-1:0] io_data
);

  localparam int NUM_M = 2;

  logic [NUM_M-1:0]                 req;
  logic [NUM_M-1:0]                 m_we;
  logic [NUM_M-1:0][ADDR_WIDTH-1:0] m_addr;
  logic [NUM_M-1:0][DATA_WIDTH-1:0] m_wdata;

  assign req     = {m1_req,   m0_req};
  assign m_we    = {m1_we,    m0_we};
  assign m_addr  = {m1_addr,  m0_addr};
  assign m_wdata = {m1_wdata, m0_wdata};

  arb_state_t            state;
  logic                  last_grant;
  logic                  sel;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  io_drv;
  logic [NUM_M-1:0]      ack_q;
  logic [NUM_M-1:0]      err_q;
  logic                  gnt_valid;
  logic                  gnt_idx;

  rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // The read-only decode covers the 6-bit register map only.
  logic [5:0] gnt_reg;
  assign gnt_reg = 6'(m_addr[gnt_idx]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      wdata_q    <= '0;
      io_drv     <= 1'b0;
      io_cs      <= 1'b0;
      io_we      <= 1'b0;
      io_oe      <= 1'b0;
      io_addr    <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata      <= '0;
    end else begin
      // acks/errs are single-cycle pulses raised on entry to RESP
      ack_q <= '0;
      err_q <= '0;
      unique case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            sel        <= gnt_idx;
            last_grant <= gnt_idx;
            wdata_q    <= m_wdata[gnt_idx];
            if (m_we[gnt_idx] && is_ro(gnt_reg)) begin
              state          <= S_RESP;
              ack_q[gnt_idx] <= 1'b1;
              err_q[gnt_idx] <= 1'b1;
            end else if (m_we[gnt_idx]) begin
              state   <= S_WRITE;
              io_cs   <= 1'b1;
              io_we   <= 1'b1;
              io_drv  <= 1'b1;
              io_addr <= m_addr[gnt_idx];
            end else begin
              state   <= S_RD_ADDR;
              io_cs   <= 1'b1;
              io_addr <= m_addr[gnt_idx];
            end
          end
        end
        S_WRITE: begin
          state      <= S_RESP;
          io_cs      <= 1'b0;
          io_we      <= 1'b0;
          io_drv     <= 1'b0;
          ack_q[sel] <= 1'b1;
        end
        S_RD_ADDR: begin
          state <= S_RD_DATA;
          io_oe <= 1'b1;
        end
        S_RD_DATA: begin
          state      <= S_RESP;
          io_cs      <= 1'b0;
          io_oe      <= 1'b0;
          rdata      <= io_data;
          ack_q[sel] <= 1'b1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io_data = io_drv ? wdata_q : 'z;

  assign m0_ack = ack_q[0];
  assign m1_ack = ack_q[1];
  assign m0_err = err_q[0];
  assign m1_err = err_q[1];

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
//   Directed bench for io_bus_arbiter with a behavioural IO SRAM
//   (negedge write / address latch, combinational read driver).
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [5:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_ack, m0_err, m1_ack, m1_err;
  logic [7:0] rdata;
  logic       io_cs, io_we, io_oe;
  logic [5:0] io_addr;
  wire  [7:0] io_data;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .rdata(rdata), .io_cs(io_cs), .io_we(io_we), .io_oe(io_oe),
    .io_addr(io_addr), .io_data(io_data)
  );

  // IO SRAM model
  logic [7:0] mem [64];
  logic [5:0] lat_addr = '0;
  assign io_data = (io_cs && io_oe && !io_we) ? mem[lat_addr] : 'z;
  always @(negedge clk) begin
    if (io_cs && io_we) mem[io_addr] <= io_data;
    if (io_cs && !io_we && !io_oe) lat_addr <= io_addr;
  end

  // Bus / handshake monitors
  int cyc = 0, cs_cnt = 0, oe_cnt = 0, ack_cnt = 0;
  int overlap_err = 0, oe_bad = 0, err_bad = 0;
  int ack_log[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (io_cs) cs_cnt <= cs_cnt + 1;
    if (io_oe) oe_cnt <= oe_cnt + 1;
    if (io_oe && (io_we || !io_cs)) oe_bad <= oe_bad + 1;
    if (m0_ack && m1_ack) overlap_err <= overlap_err + 1;
    if ((m0_err && !m0_ack) || (m1_err && !m1_ack)) err_bad <= err_bad + 1;
    if (m0_ack || m1_ack) ack_cnt <= ack_cnt + 1;
    if (m0_ack) ack_log.push_back(0);
    if (m1_ack) ack_log.push_back(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entry: #1 after a posedge with the DUT in IDLE. Returns ack latency in
  // cycles from the sampling edge (0 = no ack within budget).
  task automatic txn(input int m, input logic we, input logic [5:0] a,
                     input logic [7:0] d, output int lat, output logic err,
                     output logic [7:0] rd, output int ack_cyc);
    if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
    lat = 0; err = 0; rd = '0; ack_cyc = 0;
    @(posedge clk); #1;
    for (int n = 1; n <= 8; n++) begin
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        lat = n; err = (m == 0) ? m0_err : m1_err; rd = rdata; ack_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (m == 0) m0_req = 0; else m1_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c1, c2, c3, base;
    logic err;
    logic [7:0] rd;

    for (int i = 0; i < 64; i++) mem[i] = 8'hC0 | 8'(i);
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // reset state
    chk("rst_cs_we_oe", {io_cs, io_we, io_oe}, 3'b000);
    chk("rst_addr", io_addr, 6'h00);
    chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    chk("rst_rdata", rdata, 8'h00);

    // reset held 2 cycles while a read sits in RD_DATA
    m0_req = 1; m0_we = 0; m0_addr = PORTA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_rd_data", {io_cs, io_oe, io_we}, 3'b110);
    base = ack_cnt;
    reset = 1; m0_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("abort_bus", {io_cs, io_oe, io_we}, 3'b000);
    chk("abort_rdata", rdata, 8'h00);
    @(posedge clk); #1;
    chk("abort_no_ack", ack_cnt - base, 0);
    chk("abort_idle_bus", io_cs, 1'b0);

    // writes: DDRA then PORTA
    txn(0, 1, DDRA, 8'hFF, lat, err, rd, c1);
    chk("wr_ddra_lat", lat, 2);
    chk("wr_ddra_err", err, 1'b0);
    txn(0, 1, PORTA, 8'hA5, lat, err, rd, c1);
    chk("wr_porta_lat", lat, 2);
    chk("wr_porta_err", err, 1'b0);
    chk("mem_porta", mem[PORTA], 8'hA5);
    chk("pa_drive", mem[PORTA] & mem[DDRA], 8'hA5);

    // read back PORTA
    base = oe_cnt;
    txn(0, 0, PORTA, 8'h00, lat, err, rd, c1);
    chk("rd_porta_lat", lat, 3);
    chk("rd_porta_data", rd, 8'hA5);
    chk("rd_porta_err", err, 1'b0);
    chk("rd_oe_cycles", oe_cnt - base, 1);

    // rejected write to PINA
    base = cs_cnt;
    txn(1, 1, PINA, 8'h3C, lat, err, rd, c1);
    chk("ro_lat", lat, 1);
    chk("ro_err", err, 1'b1);
    chk("ro_no_cs", cs_cnt - base, 0);
    chk("ro_mem_pina", mem[PINA], 8'hD9);

    // continuous contention, four transactions
    ack_log.delete();
    m0_req = 1; m0_we = 1; m0_addr = 6'h10; m0_wdata = 8'h11;
    m1_req = 1; m1_we = 1; m1_addr = 6'h11; m1_wdata = 8'h22;
    for (int n = 0; n < 40 && ack_log.size() < 4; n++) begin
      @(posedge clk); #1;
    end
    m0_req = 0; m1_req = 0;
    chk("cont_count", ack_log.size(), 4);
    if (ack_log.size() >= 4) begin
      chk("cont_order", {ack_log[0][1:0], ack_log[1][1:0], ack_log[2][1:0], ack_log[3][1:0]},
          8'b00_01_00_01);
    end
    chk("cont_mem10", mem[6'h10], 8'h11);
    chk("cont_mem11", mem[6'h11], 8'h22);
    chk("rdata_held", rdata, 8'hA5);

    // single-master back-to-back
    txn(1, 0, 6'h10, 8'h00, lat, err, rd, c1);
    chk("b2b_rd1_lat", lat, 3);
    chk("b2b_rd1_data", rd, 8'h11);
    txn(1, 1, 6'h10, 8'h5A, lat, err, rd, c2);
    chk("b2b_wr_lat", lat, 2);
    txn(1, 0, 6'h10, 8'h00, lat, err, rd, c3);
    chk("b2b_rd2_lat", lat, 3);
    chk("b2b_rd2_data", rd, 8'h5A);
    chk("b2b_gap_rd_wr", c2 - c1, 3);
    chk("b2b_gap_wr_rd", c3 - c2, 4);

    // global protocol monitors
    @(posedge clk); #1;
    chk("ack_overlap", overlap_err, 0);
    chk("oe_outside_read", oe_bad, 0);
    chk("err_without_ack", err_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
